// File: rtl/ped_request_ctrl_if.sv
// Interface between the light controller side and the pedestrian request block.
// The master modport is the light controller. The slave modport is ped_request_ctrl.
interface ped_request_ctrl_if;
   logic       tick_1hz;
   logic       btn_ns;
   logic       btn_ew;
   logic       ack_ns;
   logic       ack_ew;
   logic       req_ns;
   logic       req_ew;
   logic [7:0] wait_ns;
   logic [7:0] wait_ew;

   modport master (
      output tick_1hz, btn_ns, btn_ew, ack_ns, ack_ew,
      input  req_ns, req_ew, wait_ns, wait_ew
   );

   modport slave (
      input  tick_1hz, btn_ns, btn_ew, ack_ns, ack_ew,
      output req_ns, req_ew, wait_ns, wait_ew
   );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: per-direction synchronizer, debouncer, request FSM and wait-seconds counter.
// The wait counters are built only when the macro PED_WAIT_COUNT_EN is defined; otherwise they read 0.
module ped_request_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   ped_request_ctrl_if.slave bus
);
   localparam logic [23:0] DB_LIMIT = 24'(DEBOUNCE_CYCLES);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   // Channel 0 is north-south and channel 1 is east-west.
   logic [1:0]      btn;
   logic [1:0]      ack;
   logic [1:0]      req;
   logic [1:0][7:0] wait_cnt;

   assign btn = {bus.btn_ew, bus.btn_ns};
   assign ack = {bus.ack_ew, bus.ack_ns};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic        sync1_reg;
         logic        sync2_reg;
         logic        level_reg;
         logic        level_prev_reg;
         logic [23:0] db_cnt_reg;
         logic        press;
         state_t      state_reg;
         state_t      state_next;

         // The debounced level flips on the edge after the counter records enough disagreeing cycles.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_reg      <= 1'b0;
               sync2_reg      <= 1'b0;
               level_reg      <= 1'b0;
               level_prev_reg <= 1'b0;
               db_cnt_reg     <= '0;
               state_reg      <= IDLE;
            end else begin
               sync1_reg      <= btn[gi];
               sync2_reg      <= sync1_reg;
               level_prev_reg <= level_reg;
               if (db_cnt_reg == DB_LIMIT) begin
                  level_reg  <= ~level_reg;
                  db_cnt_reg <= '0;
               end else if (sync2_reg != level_reg) begin
                  db_cnt_reg <= db_cnt_reg + 24'd1;
               end else begin
                  db_cnt_reg <= '0;
               end
               state_reg <= state_next;
            end
         end

         assign press = level_reg & ~level_prev_reg;

         always_comb begin
            state_next = state_reg;
            case (state_reg)
               IDLE:    if (press)   state_next = PENDING;
               PENDING: if (ack[gi]) state_next = IDLE;
               default: state_next = IDLE;
            endcase
         end

         assign req[gi] = (state_reg == PENDING);

`ifdef PED_WAIT_COUNT_EN
         logic [7:0] wait_reg;

         // Clearing on either side of an IDLE state also drops a tick that coincides with a new request.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wait_reg <= 8'd0;
            end else if (state_reg == IDLE || state_next == IDLE) begin
               wait_reg <= 8'd0;
            end else if (bus.tick_1hz && wait_reg != 8'hFF) begin
               wait_reg <= wait_reg + 8'd1;
            end
         end

         assign wait_cnt[gi] = wait_reg;
`else
         assign wait_cnt[gi] = 8'd0;
`endif
      end
   endgenerate

`ifndef PED_WAIT_COUNT_EN
   logic unused_tick;
   assign unused_tick = bus.tick_1hz;
`endif

   assign bus.req_ns  = req[0];
   assign bus.req_ew  = req[1];
   assign bus.wait_ns = wait_cnt[0];
   assign bus.wait_ew = wait_cnt[1];
endmodule

// File: doc/ped_request_ctrl.md
PED_REQUEST_CTRL -- requirements
Module: ped_request_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive clk cycles a synced button level must hold before it is accepted (10 ms at 100 MHz); legal range 1 to 2^24-1.
REQ-002 The block SHALL have the port clk, input, 1, the 100 MHz system clock; it is the only clock.
REQ-003 The block SHALL have the port rst, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have the port tick_1hz, input, 1, a one-clk-wide pulse once per second, synchronous to clk.
REQ-005 The block SHALL have the ports btn_ns and btn_ew, input, 1 each, raw asynchronous pedestrian buttons, active-high.
REQ-006 The block SHALL have the ports ack_ns and ack_ew, input, 1 each, one-cycle pulses from the light controller meaning "walk phase for this direction has started".
REQ-007 The block SHALL have the ports req_ns and req_ew, output, 1 each, level requests to the light controller.
REQ-008 The block SHALL have the ports wait_ns and wait_ew, output, 8 each, the seconds elapsed since the pending request was latched.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each channel SHALL keep a debounced level; it changes only after the synced level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears the debounce counter.
REQ-011 A press SHALL be a 0->1 change of the debounced level; release (1->0) SHALL generate no event.
REQ-012 Each channel SHALL be a 2-state FSM: IDLE (req=0) and PENDING (req=1).
REQ-013 IDLE + press -> PENDING; req SHALL rise on the clock edge after the debounced level rises, i.e. DEBOUNCE_CYCLES+3 edges after the first edge sampling the raw button high.
REQ-014 PENDING + ack -> IDLE; req SHALL fall on the edge that samples ack.
REQ-015 A press in PENDING SHALL be ignored; the request is not double-counted.
REQ-016 A press and ack on the same edge in PENDING: ack wins -> IDLE; the press is dropped.
REQ-017 An ack in IDLE SHALL be ignored.
REQ-018 Channels SHALL be fully independent; simultaneous events on both channels SHALL be handled per channel with no interaction.
REQ-019 The wait counter SHALL clear to 0 on IDLE->PENDING.
REQ-020 In PENDING the wait counter SHALL increment on each tick_1hz and saturate at 255.
REQ-021 The wait counter SHALL clear to 0 on PENDING->IDLE and hold 0 in IDLE.
REQ-022 A tick on the same edge as the IDLE->PENDING transition SHALL NOT count.

Reset
REQ-023 rst SHALL asynchronously clear the synchronizers, debounced levels, debounce counters, FSMs (IDLE), req_ns, req_ew, wait_ns and wait_ew to 0.
REQ-024 Reset asserted mid-debounce or mid-PENDING SHALL discard the in-progress event; a button held through reset release SHALL register as a new press after the full debounce.

Configuration
REQ-025 With macro PED_WAIT_COUNT_EN defined, the wait counters SHALL be implemented per REQ-019 to REQ-022.
REQ-026 Without PED_WAIT_COUNT_EN, wait_ns and wait_ew SHALL be tied to 0, no counter flops SHALL be built, tick_1hz SHALL be unused, and request behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Raw btn_ns high from edge 0 -> req_ns=1 from edge 7; req_ew stays 0.
REQ-028 btn_ew high for 3 cycles, then low -> req_ew never asserts.
REQ-029 req_ns pending, 300 tick_1hz pulses, PED_WAIT_COUNT_EN defined -> wait_ns=255; with the macro undefined -> wait_ns=0.
REQ-030 req_ns pending, ack_ns pulse on the same edge as a new press -> req_ns=0 and wait_ns=0 next cycle, and no re-request.
REQ-031 rst asserted asynchronously mid-PENDING -> all outputs 0 immediately, with no clock required.
REQ-032 ack_ew pulsed while IDLE, then a press -> normal assertion per REQ-013 with no side effects.
